// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and geometry for the cache-line to burst-memory adaptor.
// A 256-bit line moves as four 64-bit beats.
package cacheline_adaptor_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit line read/write into a four-beat 64-bit burst and back.
// The line buffer serves as both the read assembly buffer and the write source.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pmem_address,
  input  logic                pmem_read,
  input  logic                pmem_write,
  input  logic [LINE_W-1:0]   pmem_wdata,
  output logic [LINE_W-1:0]   pmem_rdata,
  output logic                pmem_resp,
  output logic [31:0]         mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [BEAT_W-1:0]   mem_wdata,
  input  logic [BEAT_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  state_e                         r_state;
  state_e                         w_state_next;
  logic [CNT_W-1:0]               r_cnt;
  logic [BEATS-1:0][BEAT_W-1:0]   r_buf;
  logic [31:0]                    r_addr;
  logic                           w_accept;
  logic                           w_beat;
  logic                           w_last_beat;

  assign w_accept    = (r_state == StIdle) && (pmem_read || pmem_write);
  // Beats only count while a burst is in flight; strobes in IDLE/DONE are dropped.
  assign w_beat      = ((r_state == StRead) || (r_state == StWrite)) && mem_resp;
  assign w_last_beat = w_beat && (r_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (pmem_read) begin
          w_state_next = StRead;
        end else if (pmem_write) begin
          w_state_next = StWrite;
        end
      end
      StRead, StWrite: begin
        if (w_last_beat) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_buf  <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= {pmem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      r_buf  <= pmem_wdata;
      r_cnt  <= '0;
    end else if (w_beat) begin
      if (r_state == StRead) begin
        r_buf[r_cnt] <= mem_rdata;
      end
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    mem_read    = (r_state == StRead);
    mem_write   = (r_state == StWrite);
    pmem_resp   = (r_state == StDone);
    mem_wdata   = r_buf[r_cnt];
    pmem_rdata  = r_buf;
    mem_address = r_addr;
  end

endmodule
